// File: rtl/pipelined_dmem_bridge_pkg.sv
// Shared type enums for the core and its memory-side blocks, including the data-memory
// bridge state encoding and the word-alignment mask applied to bridge bus addresses.
package pipelined_dmem_bridge_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } dmem_bridge_state_t;

    localparam logic [31:0] DMEM_BRIDGE_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_bridge_timeout_ctr.sv
// Access watchdog for the data-memory bridge: clears on request launch, counts while
// enabled and flags expiry when the count reaches LIMIT-1.
module dmem_bridge_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(LIMIT) + 1;

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = (count_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/pipelined_dmem_bridge.sv
// Converts the MEM-stage strobe port into a valid/ready request + response-valid bus,
// stalling the core while an access is in flight. Optional watchdog: DMEM_BRIDGE_TIMEOUT_EN.
module pipelined_dmem_bridge
    import pipelined_dmem_bridge_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [3:0]       i_byteen,
    input  logic             i_we,
    input  logic             i_re,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_stall,
    output logic             o_err,
    output logic             o_bus_req_valid,
    input  logic             i_bus_req_ready,
    output logic [WIDTH-1:0] o_bus_addr,
    output logic [WIDTH-1:0] o_bus_wdata,
    output logic [3:0]       o_bus_wstrb,
    output logic             o_bus_we,
    input  logic             i_bus_rsp_valid,
    input  logic [WIDTH-1:0] i_bus_rsp_data,
    input  logic             i_bus_rsp_err
);

    dmem_bridge_state_t state_reg, state_next;

    logic [WIDTH-1:0] addr_reg, addr_next;
    logic [WIDTH-1:0] wdata_reg, wdata_next;
    logic [3:0]       wstrb_reg, wstrb_next;
    logic             we_reg, we_next;
    logic [WIDTH-1:0] rdata_reg, rdata_next;
    logic             err_reg, err_next;

    logic ctr_clear;
    logic ctr_en;
    logic expire;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    dmem_bridge_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (i_clk),
        .rst_n  (i_reset),
        .clear  (ctr_clear),
        .enable (ctr_en),
        .expire (expire)
    );
`else
    logic unused_timeout;
    assign expire         = 1'b0;
    assign unused_timeout = ctr_clear ^ ctr_en ^ (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            we_reg    <= 1'b0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
            we_reg    <= we_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        we_next         = we_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;
        o_stall         = 1'b0;
        o_bus_req_valid = 1'b0;
        ctr_clear       = 1'b0;
        ctr_en          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_re || i_we) begin
                    o_stall    = 1'b1;
                    addr_next  = i_addr;
                    wdata_next = i_wdata;
                    wstrb_next = i_we ? i_byteen : 4'b0000;
                    we_next    = i_we;
                    ctr_clear  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                o_stall = 1'b1;
                ctr_en  = 1'b1;
                // Withdraw valid on the expiring cycle so an aborted access is never accepted.
                if (expire) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    o_bus_req_valid = 1'b1;
                    if (i_bus_req_ready) begin
                        state_next = RSP;
                    end
                end
            end
            RSP: begin
                o_stall = 1'b1;
                ctr_en  = 1'b1;
                if (i_bus_rsp_valid) begin
                    rdata_next = i_bus_rsp_err ? '0 : i_bus_rsp_data;
                    err_next   = i_bus_rsp_err;
                    state_next = DONE;
                end else if (expire) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_rdata     = rdata_reg;
    assign o_err       = (state_reg == DONE) && err_reg;
    assign o_bus_addr  = addr_reg & WIDTH'(DMEM_BRIDGE_ADDR_ALIGN_MASK);
    assign o_bus_wdata = wdata_reg;
    assign o_bus_wstrb = wstrb_reg;
    assign o_bus_we    = we_reg;

endmodule

// File: tb/tb_pipelined_dmem_bridge.sv
// Directed bench for pipelined_dmem_bridge: vector table driven against a delay-programmable
// bus responder, plus hand-written reset and watchdog sequences.
module tb_pipelined_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata;
    logic [3:0]  byteen;
    logic        we, re;
    logic [31:0] rdata;
    logic        stall, err;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_we;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_data;
    logic        bus_rsp_err;

    always #5 clk = ~clk;

    pipelined_dmem_bridge #(
        .WIDTH          (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_addr          (addr),
        .i_wdata         (wdata),
        .i_byteen        (byteen),
        .i_we            (we),
        .i_re            (re),
        .o_rdata         (rdata),
        .o_stall         (stall),
        .o_err           (err),
        .o_bus_req_valid (bus_req_valid),
        .i_bus_req_ready (bus_req_ready),
        .o_bus_addr      (bus_addr),
        .o_bus_wdata     (bus_wdata),
        .o_bus_wstrb     (bus_wstrb),
        .o_bus_we        (bus_we),
        .i_bus_rsp_valid (bus_rsp_valid),
        .i_bus_rsp_data  (bus_rsp_data),
        .i_bus_rsp_err   (bus_rsp_err)
    );

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
        int          ready_dly;
        int          rsp_dly;
        logic [31:0] rsp_data;
        logic        rsp_err;
        logic        chain;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic        exp_we;
        int          exp_stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // responder configuration and observations
    logic        resp_en = 1'b0;
    int          ready_dly_cfg = 0;
    int          rsp_dly_cfg = 0;
    logic [31:0] rsp_data_cfg = '0;
    logic        rsp_err_cfg = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we;
    logic        stable_bad = 1'b0;
    int          req_count = 0;

    always_ff @(posedge clk) begin
        if (bus_req_valid && bus_req_ready) req_count <= req_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] be, input int rd,
                                input int rs, input logic [31:0] rsd, input logic rse,
                                input logic ch, input logic [31:0] ea, input logic [3:0] ews,
                                input logic ewe, input int est, input logic [31:0] erd,
                                input logic eer);
        vec_t v;
        v.re = r; v.we = w; v.addr = a; v.wdata = d; v.byteen = be;
        v.ready_dly = rd; v.rsp_dly = rs; v.rsp_data = rsd; v.rsp_err = rse; v.chain = ch;
        v.exp_addr = ea; v.exp_wstrb = ews; v.exp_we = ewe; v.exp_stall = est;
        v.exp_rdata = erd; v.exp_err = eer;
        return v;
    endfunction

    // Bus model: ready after ready_dly REQ cycles, one-cycle response after rsp_dly RSP cycles.
    initial begin
        int   phase = 0;
        int   wcnt = 0;
        logic hs_prev = 1'b0;
        logic first = 1'b1;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                phase = 0; wcnt = 0; hs_prev = 1'b0; first = 1'b1;
            end else begin
                if (hs_prev) begin
                    phase = 1; wcnt = 0; bus_req_ready = 1'b0;
                end
                hs_prev = 1'b0;
                case (phase)
                    0: begin
                        bus_rsp_valid = 1'b0;
                        if (bus_req_valid) begin
                            if (first) begin
                                cap_addr = bus_addr; cap_wdata = bus_wdata;
                                cap_wstrb = bus_wstrb; cap_we = bus_we; first = 1'b0;
                            end else if ({bus_addr, bus_wdata, bus_wstrb, bus_we} !==
                                         {cap_addr, cap_wdata, cap_wstrb, cap_we}) begin
                                stable_bad = 1'b1;
                            end
                            if (wcnt >= ready_dly_cfg) begin
                                bus_req_ready = 1'b1; hs_prev = 1'b1;
                            end else begin
                                bus_req_ready = 1'b0; wcnt++;
                            end
                        end else begin
                            bus_req_ready = 1'b0;
                        end
                    end
                    1: begin
                        if (wcnt >= rsp_dly_cfg) begin
                            bus_rsp_valid = 1'b1; bus_rsp_data = rsp_data_cfg;
                            bus_rsp_err = rsp_err_cfg; phase = 2;
                        end else begin
                            wcnt++;
                        end
                    end
                    default: begin
                        bus_rsp_valid = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
                        phase = 0; wcnt = 0; first = 1'b1;
                    end
                endcase
            end
        end
    end

    task automatic run_vec(input vec_t v, input string nm);
        int stalls;
        int req0;
        logic done;
        stalls = 0;
        done = 1'b0;
        req0 = req_count;
        ready_dly_cfg = v.ready_dly; rsp_dly_cfg = v.rsp_dly;
        rsp_data_cfg = v.rsp_data;   rsp_err_cfg = v.rsp_err;
        stable_bad = 1'b0;
        @(posedge clk); #1;
        re = v.re; we = v.we; addr = v.addr; wdata = v.wdata; byteen = v.byteen;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
        end
        check({nm, " completes"}, 32'(done), 32'd1);
        check({nm, " stall cycles"}, 32'(stalls), 32'(v.exp_stall));
        check({nm, " rdata"}, rdata, v.exp_rdata);
        check({nm, " err"}, 32'(err), 32'(v.exp_err));
        check({nm, " bus addr"}, cap_addr, v.exp_addr);
        check({nm, " bus wdata"}, cap_wdata, v.wdata);
        check({nm, " bus wstrb"}, 32'(cap_wstrb), 32'(v.exp_wstrb));
        check({nm, " bus we"}, 32'(cap_we), 32'(v.exp_we));
        check({nm, " fields stable"}, 32'(stable_bad), 32'd0);
        check({nm, " one request"}, 32'(req_count - req0), 32'd1);
        $display("[TB] %s: addr=0x%08h stalls=%0d rdata=0x%08h err=%0b", nm, v.addr, stalls, rdata, err);
        if (!v.chain) begin
            @(posedge clk); #1;
            re = 1'b0; we = 1'b0;
            @(negedge clk);
            check({nm, " idle stall"}, 32'(stall), 32'd0);
            check({nm, " idle req_valid"}, 32'(bus_req_valid), 32'd0);
            check({nm, " err pulse ends"}, 32'(err), 32'd0);
            check({nm, " rdata holds"}, rdata, v.exp_rdata);
        end
    endtask

    vec_t vecs[7];
    vec_t rec;

    initial begin
        int req_before;
        int stalls;
        logic done;

        rst_n = 1'b0;
        re = 1'b0; we = 1'b0; addr = '0; wdata = '0; byteen = '0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;

        //            re    we    addr          wdata         be      rdy rsp rsp_data      rerr  chain exp_addr      wstrb   we    st exp_rdata     eerr
        vecs[0] = mk(1'b1, 1'b0, 32'h0000_0103, 32'h0000_0000, 4'b0000, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 1'b0, 3, 32'hDEAD_BEEF, 1'b0);
        vecs[1] = mk(1'b0, 1'b1, 32'h0000_2002, 32'h0000_AB00, 4'b0010, 5, 0, 32'h1111_1111, 1'b0, 1'b0, 32'h0000_2000, 4'b0010, 1'b1, 8, 32'h1111_1111, 1'b0);
        vecs[2] = mk(1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'b1111, 0, 0, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0040, 4'b0000, 1'b0, 3, 32'h0000_0000, 1'b1);
        vecs[3] = mk(1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 4'b0000, 0, 2, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0000_0300, 4'b0000, 1'b0, 5, 32'hA5A5_A5A5, 1'b0);
        vecs[4] = mk(1'b1, 1'b0, 32'h0000_0304, 32'h0000_0000, 4'b0000, 0, 0, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0000_0304, 4'b0000, 1'b0, 3, 32'h5A5A_5A5A, 1'b0);
        vecs[5] = mk(1'b1, 1'b1, 32'h0000_0507, 32'hCAFE_F00D, 4'b1111, 1, 1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0504, 4'b1111, 1'b1, 5, 32'h0000_0000, 1'b0);
        vecs[6] = mk(1'b1, 1'b0, 32'h0000_0A0E, 32'h0000_0000, 4'b0000, 2, 3, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0000_0A0C, 4'b0000, 1'b0, 8, 32'h0BAD_F00D, 1'b0);

        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset req_valid", 32'(bus_req_valid), 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset bus addr", bus_addr, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        resp_en = 1'b1;

        req_before = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) req_before = req_count;
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 4) begin
                repeat (2) @(negedge clk);
                check("b2b total requests", 32'(req_count - req_before), 32'd2);
            end
        end

        // reset in RSP, then a late response must be ignored
        resp_en = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        @(posedge clk); #1;
        re = 1'b1; we = 1'b0; addr = 32'h0000_0600;
        @(negedge clk);
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        re = 1'b0;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        @(negedge clk);
        check("rst seq in RSP stall", 32'(stall), 32'd1);
        check("rst seq in RSP req_valid", 32'(bus_req_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid-access reset stall", 32'(stall), 32'd0);
        check("mid-access reset req_valid", 32'(bus_req_valid), 32'd0);
        check("mid-access reset rdata", rdata, 32'd0);
        check("mid-access reset bus addr", bus_addr, 32'd0);
        check("mid-access reset bus we", 32'(bus_we), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'hFFFF_FFFF; bus_rsp_err = 1'b1;
        @(negedge clk);
        check("late rsp stall", 32'(stall), 32'd0);
        check("late rsp req_valid", 32'(bus_req_valid), 32'd0);
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
        @(negedge clk);
        check("late rsp ignored rdata", rdata, 32'd0);
        check("late rsp ignored err", 32'(err), 32'd0);
        $display("[TB] reset-in-RSP: stall=%0b rdata=0x%08h err=%0b", stall, rdata, err);
        resp_en = 1'b1;
        rec = mk(1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'b0000, 0, 0, 32'h1357_9BDF, 1'b0, 1'b0,
                 32'h0000_0700, 4'b0000, 1'b0, 3, 32'h1357_9BDF, 1'b0);
        run_vec(rec, "recovery");

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        resp_en = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        stalls = 0;
        done = 1'b0;
        @(posedge clk); #1;
        re = 1'b1; we = 1'b0; addr = 32'h0000_0800;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
        end
        check("timeout completes", 32'(done), 32'd1);
        check("timeout stall cycles", 32'(stalls), 32'd9);
        check("timeout err", 32'(err), 32'd1);
        check("timeout rdata", rdata, 32'd0);
        check("timeout req_valid dropped", 32'(bus_req_valid), 32'd0);
        $display("[TB] timeout: stalls=%0d err=%0b", stalls, err);
        @(posedge clk); #1;
        re = 1'b0;
        @(negedge clk);
        check("timeout err pulse ends", 32'(err), 32'd0);
`else
        stalls = 0;
        done = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
